control_unit_multicycle: RTL and testbench
==========================================

// Module: control_unit_multicycle
// PURPOSE
// Multi-cycle control FSM that decodes the fetched instruction and drives the temporary RISC-V datapath
// control inputs (register/data-memory write enables, result/operand mux selects, add/sub), plus PC/IR load strobes.
// Sits directly upstream of the datapath: replaces the hand-driven control vectors used to exercise it today.
// Supports lw, sw, add, sub, addi and beq/bne/blt/bge/bltu/bgeu; anything else traps.
// PARAMETERS
// INSTR_WIDTH      32  instruction word width (only 32 supported)
// TRAP_ON_ILLEGAL  1   1: illegal opcode enters TRAP (sticky); 0: treated as NOP (return to FETCH)
// PORTS
// clk                      in   1   system clock, rising edge
// reset                    in   1   asynchronous, active-low reset
// run                      in   1   1: allow next fetch; 0: hold in FETCH (halt)
// instruction              in   32  instruction-memory output at current PC
// zero                     in   1   ALU result == 0 (from datapath)
// lessThan                 in   1   signed rs1 < rs2 (from datapath)
// lessThanU                in   1   unsigned rs1 < rs2 (from datapath)
// loadIR                   out  1   latch instruction register
// loadPC                   out  1   PC write enable
// pcSrc                    out  1   0: PC+4, 1: PC+imm (branch target)
// writeEnable_Registers    out  1   register-file write enable
// writeEnable_DataMemory   out  1   data-memory write enable
// muxSelect_SumVsReadData  out  1   0: read data to RF, 1: ALU sum to RF
// muxSelect_ImmVsDataout2  out  1   0: immediate to ALU B, 1: Dataout2 to ALU B
// SumOrSub                 out  1   0: add, 1: subtract
// illegal                  out  1   sticky illegal-instruction flag
// BEHAVIOUR
// - Reset (reset=0, async): state=FETCH; IR cleared; all outputs 0. Reset mid-instruction aborts with no partial write.
// - States: FETCH, DECODE, EXEC, MEM, WB, TRAP. One state per cycle; the state register is the only sequential control.
// - FETCH: if run, loadIR=1 for 1 cycle -> DECODE; else stay, all strobes 0.
// - DECODE: classify opcode from IR -> EXEC (legal) or TRAP/FETCH (illegal, per TRAP_ON_ILLEGAL).
// - EXEC: ALU set-up. R: ImmVsDataout2=1, SumOrSub=funct7[5]. addi/lw/sw: ImmVsDataout2=0, SumOrSub=0.
//   Branch: ImmVsDataout2=1, SumOrSub=1, loadPC=1, pcSrc=taken -> FETCH. R/addi -> WB; lw/sw -> MEM.
// - MEM: sw: writeEnable_DataMemory=1, loadPC=1, pcSrc=0 -> FETCH. lw: read cycle -> WB.
// - WB: writeEnable_Registers=1, loadPC=1, pcSrc=0; SumVsReadData=1 for R/addi, 0 for lw -> FETCH.
// - Mux selects/SumOrSub stay stable from EXEC to the end of the instruction; write enables and loadPC are 1-cycle pulses.
// - Latency (cycles, FETCH inclusive): branch 3, R/addi 4, sw 4, lw 5.
// - Branch taken: beq zero; bne !zero; blt lessThan; bge !lessThan; bltu lessThanU; bgeu !lessThanU.
//   Branch funct3 010/011 is illegal.
// - Legal encodings: lw 0000011/f3=010; sw 0100011/f3=010; addi 0010011/f3=000;
//   R 0110011/f3=000/f7 in {0000000,0100000}; branch 1100011.
// - TRAP: illegal=1; all strobes 0; exits only on reset.
// - Write enables are never asserted in the same cycle as loadIR. pcSrc=0 whenever loadPC=0.
// STRUCTURE
// - Shared package riscv_ctrl_pkg: opcode/funct3/funct7 constants, state encoding, instruction-class enum.
// - Sub-module branch_resolver (combinational: funct3, zero, lessThan, lessThanU -> taken, bad_funct3).
// - Top: IR register, state register, next-state logic, Moore output decode (flags are sampled only in EXEC).
// TESTING
// - Reset: hold reset=0 for 2 cycles mid-lw -> all outputs 0, state FETCH; release -> loadIR at first edge with run=1.
// - lw x1,0(x0) 0x00002083 -> 5 cycles; WB: writeEnable_Registers=1, SumVsReadData=0, loadPC=1, pcSrc=0.
// - add 0x001101B3 then sub x4,x3,x1 0x40118233 -> EXEC SumOrSub 0 then 1, ImmVsDataout2=1;
//   WB SumVsReadData=1; 4 cycles each.
// - sw x3,24(x0) 0x00302C23 -> MEM: writeEnable_DataMemory=1, writeEnable_Registers=0; addi 0x00308293 -> ImmVsDataout2=0.
// - All six branch funct3 values, each with flags 0 and 1: pcSrc matches the taken table, loadPC=1 in EXEC,
//   no write enable, 3 cycles.
// - Illegal 0x00000000 -> TRAP, illegal=1 sticky; run=0 in FETCH -> no loadIR for 10 cycles.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: opcode/funct fields,
// FSM states and the instruction classes the decoder distinguishes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD,
    C_STORE,
    C_ADDI,
    C_RTYPE,
    C_BRANCH,
    C_ILLEGAL
  } iclass_t;

  function automatic iclass_t classify(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic bad_branch_f3);
    iclass_t c;
    c = C_ILLEGAL;
    case (op)
      OP_LOAD:   if (f3 == F3_LW)   c = C_LOAD;
      OP_STORE:  if (f3 == F3_SW)   c = C_STORE;
      OP_IMM:    if (f3 == F3_ADDI) c = C_ADDI;
      OP_REG:    if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) c = C_RTYPE;
      OP_BRANCH: if (!bad_branch_f3) c = C_BRANCH;
      default:   c = C_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_multicycle_branch_resolver.sv
// Branch condition evaluation from the datapath comparison flags; also flags
// the two reserved branch funct3 encodings.
module branch_resolver
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_less_than,
  input  logic       i_less_than_u,
  output logic       o_taken,
  output logic       o_bad_funct3
);

  always_comb begin
    o_taken      = 1'b0;
    o_bad_funct3 = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_zero;
      F3_BNE:  o_taken = ~i_zero;
      F3_BLT:  o_taken = i_less_than;
      F3_BGE:  o_taken = ~i_less_than;
      F3_BLTU: o_taken = i_less_than_u;
      F3_BGEU: o_taken = ~i_less_than_u;
      default: o_bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_multicycle.sv
// Multi-cycle control FSM: latches the instruction, steps FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath write enables, mux selects and PC/IR strobes (Moore outputs).
module control_unit_multicycle
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH     = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   zero,
  input  logic                   lessThan,
  input  logic                   lessThanU,
  output logic                   loadIR,
  output logic                   loadPC,
  output logic                   pcSrc,
  output logic                   writeEnable_Registers,
  output logic                   writeEnable_DataMemory,
  output logic                   muxSelect_SumVsReadData,
  output logic                   muxSelect_ImmVsDataout2,
  output logic                   SumOrSub,
  output logic                   illegal
);

  state_t                 r_state;
  state_t                 w_next;
  logic [INSTR_WIDTH-1:0] r_ir;
  iclass_t                w_class;
  logic                   w_taken;
  logic                   w_bad_funct3;
  logic                   w_in_instr;

  branch_resolver u_branch_resolver (
    .i_funct3      (r_ir[14:12]),
    .i_zero        (zero),
    .i_less_than   (lessThan),
    .i_less_than_u (lessThanU),
    .o_taken       (w_taken),
    .o_bad_funct3  (w_bad_funct3)
  );

  assign w_class    = classify(r_ir[6:0], r_ir[14:12], r_ir[31:25], w_bad_funct3);
  assign w_in_instr = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (loadIR) r_ir <= instruction;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (run) w_next = S_DECODE;
      S_DECODE: begin
        if (w_class == C_ILLEGAL) w_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        else                      w_next = S_EXEC;
      end
      S_EXEC: begin
        case (w_class)
          C_BRANCH:         w_next = S_FETCH;
          C_LOAD, C_STORE:  w_next = S_MEM;
          default:          w_next = S_WB;
        endcase
      end
      S_MEM:    w_next = (w_class == C_STORE) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    loadIR                  = 1'b0;
    loadPC                  = 1'b0;
    pcSrc                   = 1'b0;
    writeEnable_Registers   = 1'b0;
    writeEnable_DataMemory  = 1'b0;
    muxSelect_SumVsReadData = 1'b0;
    muxSelect_ImmVsDataout2 = 1'b0;
    SumOrSub                = 1'b0;
    illegal                 = 1'b0;

    // Selects are a function of the class alone so they hold steady EXEC..WB.
    if (w_in_instr) begin
      case (w_class)
        C_RTYPE: begin
          muxSelect_SumVsReadData = 1'b1;
          muxSelect_ImmVsDataout2 = 1'b1;
          SumOrSub                = r_ir[30];
        end
        C_ADDI:   muxSelect_SumVsReadData = 1'b1;
        C_BRANCH: begin
          muxSelect_ImmVsDataout2 = 1'b1;
          SumOrSub                = 1'b1;
        end
        default: ;
      endcase
    end

    case (r_state)
      // Gated by reset so nothing strobes while reset is held in FETCH.
      S_FETCH: loadIR = run & reset;
      S_EXEC: begin
        if (w_class == C_BRANCH) begin
          loadPC = 1'b1;
          pcSrc  = w_taken;
        end
      end
      S_MEM: begin
        if (w_class == C_STORE) begin
          writeEnable_DataMemory = 1'b1;
          loadPC                 = 1'b1;
        end
      end
      S_WB: begin
        writeEnable_Registers = 1'b1;
        loadPC                = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_multicycle.sv
// Bench for control_unit_multicycle: directed table, randomized instruction stream
// against a per-cycle reference model, plus reset/halt/trap sequences.
module tb_control_unit_multicycle;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] instruction;
  logic        zero, lessThan, lessThanU;
  logic        loadIR, loadPC, pcSrc, weRF, weDM, sumRd, immD2, sumSub, illegal;
  logic [8:0]  w_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  control_unit_multicycle #(
    .INSTR_WIDTH     (32),
    .TRAP_ON_ILLEGAL (1)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .run                     (run),
    .instruction             (instruction),
    .zero                    (zero),
    .lessThan                (lessThan),
    .lessThanU               (lessThanU),
    .loadIR                  (loadIR),
    .loadPC                  (loadPC),
    .pcSrc                   (pcSrc),
    .writeEnable_Registers   (weRF),
    .writeEnable_DataMemory  (weDM),
    .muxSelect_SumVsReadData (sumRd),
    .muxSelect_ImmVsDataout2 (immD2),
    .SumOrSub                (sumSub),
    .illegal                 (illegal)
  );

  // Word layout: loadIR loadPC pcSrc weRF weDM SumVsReadData ImmVsDataout2 SumOrSub illegal
  assign w_out = {loadIR, loadPC, pcSrc, weRF, weDM, sumRd, immD2, sumSub, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic        z, lt, ltu;
    int unsigned len;
    logic [8:0]  commit;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  // Reference model: 0 lw, 1 sw, 2 addi, 3 R, 4 branch, 5 illegal
  function automatic int ref_kind(input logic [31:0] ins);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    if (op == 7'h03 && f3 == 3'd2) return 0;
    if (op == 7'h23 && f3 == 3'd2) return 1;
    if (op == 7'h13 && f3 == 3'd0) return 2;
    if (op == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) return 3;
    if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) return 4;
    return 5;
  endfunction

  function automatic int unsigned ref_len(input int kind);
    case (kind)
      0:       return 5;
      4:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z, lt, ltu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      default: return !ltu;
    endcase
  endfunction

  // Expected outputs 'cyc' cycles after the fetch; the final cycle commits.
  function automatic logic [8:0] ref_word(input logic [31:0] ins, input int unsigned cyc,
                                          input logic z, lt, ltu);
    logic [8:0] w;
    int k;
    w = '0;
    k = ref_kind(ins);
    if (cyc == 0) w[8] = 1'b1;
    else if (cyc == 1) w = '0;
    else if (k == 5) w[0] = 1'b1;
    else begin
      case (k)
        2: w[3] = 1'b1;
        3: begin w[3] = 1'b1; w[2] = 1'b1; w[1] = ins[30]; end
        4: begin w[2] = 1'b1; w[1] = 1'b1; end
        default: ;
      endcase
      if (cyc == ref_len(k) - 1) begin
        w[7] = 1'b1;
        if (k == 4) w[6] = ref_taken(ins[14:12], z, lt, ltu);
        if (k == 0 || k == 2 || k == 3) w[5] = 1'b1;
        if (k == 1) w[4] = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 expecting FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z, lt, ltu, input bit jitter,
                           input int unsigned len, input bit chk_commit,
                           input logic [8:0] commit, input string tag);
    logic [31:0] rnd;
    instruction = ins;
    run         = 1'b1;
    zero        = z;
    lessThan    = lt;
    lessThanU   = ltu;
    for (int unsigned cyc = 0; cyc < len; cyc++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, cyc), w_out,
            ref_word(ins, cyc, zero, lessThan, lessThanU));
      if (chk_commit && cyc == len - 1) check($sformatf("%s commit", tag), w_out, commit);
      @(posedge clk);
      #1;
      rnd = $urandom;
      if (cyc == 0) instruction = rnd;
      if (jitter) begin
        rnd       = $urandom;
        zero      = rnd[0];
        lessThan  = rnd[1];
        lessThanU = rnd[2];
      end
    end
  endtask

  task automatic idle(input int unsigned n, input string tag);
    run = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d", tag, i), w_out, '0);
      @(posedge clk);
      #1;
    end
    run = 1'b1;
  endtask

  task automatic run_illegal(input logic [31:0] ins, input string tag);
    logic [31:0] rnd;
    instruction = ins;
    run         = 1'b1;
    @(negedge clk);
    check({tag, " fetch"}, w_out, 9'b1_0000_0000);
    @(posedge clk);
    #1;
    rnd = $urandom;
    instruction = rnd;
    @(negedge clk);
    check({tag, " decode"}, w_out, '0);
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      run = rnd[i];
      @(negedge clk);
      check($sformatf("%s trap%0d", tag, i), w_out, 9'b0_0000_0001);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b1;
    @(negedge clk);
    check({tag, " trap reset"}, w_out, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int unsigned f3s[6];
    logic [31:0] rnd, ins;
    logic [2:0]  f3;
    logic        taken, fz, flt, fltu;
    int          k;

    f3s = '{0, 1, 4, 5, 6, 7};
    tbl.push_back('{32'h00002083, 1'b0, 1'b0, 1'b0, 5, 9'b0_1_0_1_0_0_0_0_0, "lw"});
    tbl.push_back('{32'h001101B3, 1'b1, 1'b0, 1'b1, 4, 9'b0_1_0_1_0_1_1_0_0, "add"});
    tbl.push_back('{32'h40118233, 1'b0, 1'b1, 1'b0, 4, 9'b0_1_0_1_0_1_1_1_0, "sub"});
    tbl.push_back('{32'h00302C23, 1'b1, 1'b1, 1'b1, 4, 9'b0_1_0_0_1_0_0_0_0, "sw"});
    tbl.push_back('{32'h00308293, 1'b0, 1'b0, 1'b1, 4, 9'b0_1_0_1_0_1_0_0_0, "addi"});
    for (int i = 0; i < 6; i++) begin
      for (int v = 0; v < 2; v++) begin
        f3    = f3s[i][2:0];
        fz    = (f3[2:1] == 2'b00) ? v[0] : !v[0];
        flt   = (f3[2:1] == 2'b10) ? v[0] : !v[0];
        fltu  = (f3[2:1] == 2'b11) ? v[0] : !v[0];
        taken = v[0] ^ f3[0];
        tbl.push_back('{32'h00208063 | (32'(f3) << 12), fz, flt, fltu, 3,
                        {2'b01, taken, 6'b000110}, $sformatf("br f3=%0d flag=%0d", f3, v)});
      end
    end

    reset       = 1'b0;
    run         = 1'b1;
    instruction = 32'h00002083;
    zero        = 1'b1;
    lessThan    = 1'b1;
    lessThanU   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d", i), w_out, '0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (tbl[i])
      run_instr(tbl[i].ins, tbl[i].z, tbl[i].lt, tbl[i].ltu, 1'b0,
                tbl[i].len, 1'b1, tbl[i].commit, tbl[i].tag);

    for (int n = 0; n < 60; n++) begin
      rnd = $urandom;
      k   = int'($urandom_range(0, 4));
      case (k)
        0: ins = {rnd[31:15], 3'b010, rnd[11:7], 7'b0000011};
        1: ins = {rnd[31:15], 3'b010, rnd[11:7], 7'b0100011};
        2: ins = {rnd[31:15], 3'b000, rnd[11:7], 7'b0010011};
        3: ins = {1'b0, rnd[31], 5'b00000, rnd[24:15], 3'b000, rnd[11:7], 7'b0110011};
        default: begin
          f3  = f3s[$urandom_range(0, 5)][2:0];
          ins = {rnd[31:15], f3, rnd[11:7], 7'b1100011};
        end
      endcase
      if (rnd[14:13] == 2'b00) idle(1 + rnd[6:5], $sformatf("rnd%0d", n));
      run_instr(ins, rnd[0], rnd[1], rnd[2], 1'b1, ref_len(ref_kind(ins)), 1'b0, '0,
                $sformatf("rnd%0d k%0d", n, k));
    end

    idle(10, "halt");

    run_illegal(32'h00000000, "illegal zero");
    run_illegal(32'h0020A063, "illegal br f3=2");
    run_illegal(32'h02208033, "illegal R f7");
    run_illegal(32'h00000003, "illegal lb");

    instruction = 32'h00002083;
    run         = 1'b1;
    @(negedge clk);
    check("midlw fetch", w_out, 9'b1_0000_0000);
    @(posedge clk);
    #1;
    instruction = 32'h00000000;
    @(negedge clk);
    check("midlw decode", w_out, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("midlw reset%0d", i), w_out, '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    run_instr(32'h00002083, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 9'b0_1_0_1_0_0_0_0_0, "lw after reset");
    run_instr(32'h001101B3, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 9'b0_1_0_1_0_1_1_0_0, "add tail");
    @(negedge clk);
    check("final fetch", w_out, 9'b1_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
